// File: rtl/x9_instr_encoder.sv
// X9 instruction encoder/loader: encodes opcode/operand field sets into 9-bit words,
// stages them in a small FIFO and writes them one per cycle into instruction memory.
module x9_instr_encoder #(
    parameter int unsigned AW     = 8,
    parameter int unsigned FDEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [2:0]    in_rd,
    input  logic [3:0]    in_arg,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [8:0]    mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count
);

    localparam int unsigned PW  = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned AW1 = AW + 1;
    localparam logic [AW:0]   CAP      = {1'b1, {AW{1'b0}}};
    localparam logic [CW-1:0] FULL_CNT = CW'(FDEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    logic [8:0]    fifo [FDEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr;
    logic [AW:0]   pushed;

    logic          legal;
    logic [8:0]    word;
    logic          full;
    logic          empty;
    logic          pop;
    logic          accept;
    logic          ovf;
    logic          push;

    always_comb begin
        legal  = !(in_op[4] && (in_op[2:0] != 3'b000));
        word   = in_op[4] ? {in_op[4:3], in_rd, in_arg} : {in_op, in_arg};
        full   = (cnt == FULL_CNT);
        empty  = (cnt == '0);
        pop    = ((state == S_LOAD) || (state == S_DRAIN)) && !empty;
        // A full FIFO is always being popped in LOAD, so a push can land the same cycle.
        in_ready = (state == S_LOAD) && (!full || pop);
        accept = in_valid && in_ready;
        ovf    = (pushed == CAP);
        push   = accept && legal && !ovf;
    end

    assign busy = (state == S_LOAD) || (state == S_DRAIN);
    assign done = (state == S_DONE);
    assign err  = (state == S_ERR);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wptr] <= word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            addr       <= '0;
            pushed     <= '0;
            word_count <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (pop) begin
                mem_we     <= 1'b1;
                mem_addr   <= addr;
                mem_wdata  <= fifo[rptr];
                rptr       <= rptr + PW'(1);
                addr       <= addr + AW'(1);
                word_count <= word_count + AW1'(1);
            end
            if (push) begin
                wptr   <= wptr + PW'(1);
                pushed <= pushed + AW1'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LOAD;
                        addr       <= '0;
                        word_count <= '0;
                        pushed     <= '0;
                        wptr       <= '0;
                        rptr       <= '0;
                        cnt        <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (!legal || ovf) begin
                            // Queued words are dropped; a head popped this same cycle still writes.
                            state <= S_ERR;
                            wptr  <= '0;
                            rptr  <= '0;
                            cnt   <= '0;
                        end else if (in_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (empty) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x9_instr_encoder.sv
// Directed bench for x9_instr_encoder: a default instance (AW=8) and a small one (AW=2)
// used for the program-capacity overflow case.
module tb_x9_instr_encoder;

    logic       clk;
    logic       rst_n;
    logic       start_a;
    logic       start_b;
    logic       in_valid;
    logic [4:0] in_op;
    logic [2:0] in_rd;
    logic [3:0] in_arg;
    logic       in_last;

    logic       in_ready_a, mem_we_a, busy_a, done_a, err_a;
    logic [7:0] mem_addr_a;
    logic [8:0] mem_wdata_a;
    logic [8:0] word_count_a;

    logic       in_ready_b, mem_we_b, busy_b, done_b, err_b;
    logic [1:0] mem_addr_b;
    logic [8:0] mem_wdata_b;
    logic [2:0] word_count_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] addr;
        logic [8:0] data;
        int         cyc;
    } wr_t;

    wr_t wq_a[$];
    wr_t wq_b[$];

    x9_instr_encoder #(.AW(8), .FDEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_op(in_op), .in_rd(in_rd), .in_arg(in_arg), .in_last(in_last),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .busy(busy_a), .done(done_a), .err(err_a), .word_count(word_count_a)
    );

    x9_instr_encoder #(.AW(2), .FDEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_op(in_op), .in_rd(in_rd), .in_arg(in_arg), .in_last(in_last),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .busy(busy_b), .done(done_b), .err(err_b), .word_count(word_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write logger: samples 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (mem_we_a === 1'b1) wq_a.push_back('{mem_addr_a, mem_wdata_a, cyc});
        if (mem_we_b === 1'b1) wq_b.push_back('{{6'b0, mem_addr_b}, mem_wdata_b, cyc});
    end

    task automatic pulse_start(input bit use_b);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [3:0] arg,
                        input logic last, input bit use_b, output int waits);
        in_op = op; in_rd = rd; in_arg = arg; in_last = last; in_valid = 1'b1;
        waits = 0;
        while (!(use_b ? in_ready_b : in_ready_a) && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 20) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n;
        n = 0;
        while (done_a !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (done_a !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", tag, done_a, n);
        end
    endtask

    task automatic test_reset;
        total++;
        if ({in_ready_a, mem_we_a, busy_a, done_a, err_a, mem_addr_a, mem_wdata_a, word_count_a} !== '0) begin
            bad++;
            $display("FAIL reset_outputs_a: got rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h wc=%0d, required all 0",
                     in_ready_a, mem_we_a, busy_a, done_a, err_a, mem_addr_a, mem_wdata_a, word_count_a);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if ({in_ready_b, mem_we_b, busy_b, done_b, err_b, mem_addr_b, mem_wdata_b, word_count_b} !== '0) begin
            bad++;
            $display("FAIL reset_outputs_b: got rdy=%b we=%b busy=%b done=%b err=%b wc=%0d, required all 0",
                     in_ready_b, mem_we_b, busy_b, done_b, err_b, word_count_b);
        end
        total++;
        if (in_ready_a !== 1'b0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_release: rdy=%b busy=%b, required 0 0", in_ready_a, busy_a);
        end
    endtask

    task automatic test_single;
        int w;
        wq_a.delete();
        pulse_start(1'b0);
        total++;
        if (busy_a !== 1'b1 || in_ready_a !== 1'b1) begin
            bad++;
            $display("FAIL single_load: busy=%b rdy=%b, required 1 1", busy_a, in_ready_a);
        end
        send(5'b00000, 3'd0, 4'd3, 1'b1, 1'b0, w);
        total++;
        if (mem_we_a !== 1'b0) begin
            bad++;
            $display("FAIL single_we_early: mem_we=%b, required 0", mem_we_a);
        end
        @(posedge clk); #1;
        total++;
        if (mem_we_a !== 1'b1 || mem_addr_a !== 8'd0 || mem_wdata_a !== 9'b0_0000_0011 || word_count_a !== 9'd1) begin
            bad++;
            $display("FAIL single_write: we=%b addr=%0d data=%b wc=%0d, required 1 0 000000011 1",
                     mem_we_a, mem_addr_a, mem_wdata_a, word_count_a);
        end
        total++;
        if (done_a !== 1'b0) begin
            bad++;
            $display("FAIL single_done_early: done=%b, required 0", done_a);
        end
        @(posedge clk); #1;
        total++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || mem_we_a !== 1'b0 || word_count_a !== 9'd1) begin
            bad++;
            $display("FAIL single_done: done=%b busy=%b we=%b wc=%0d, required 1 0 0 1",
                     done_a, busy_a, mem_we_a, word_count_a);
        end
    endtask

    task automatic test_mov;
        int w;
        wq_a.delete();
        pulse_start(1'b0);
        send(5'b11000, 3'd5, 4'd9, 1'b0, 1'b0, w);
        send(5'b10000, 3'd2, 4'd7, 1'b1, 1'b0, w);
        wait_done_a("mov");
        total++;
        if (wq_a.size() != 2) begin
            bad++;
            $display("FAIL mov_count: writes=%0d, required 2", wq_a.size());
        end else begin
            if (wq_a[0].addr !== 8'd0 || wq_a[0].data !== 9'b1_1101_1001) begin
                bad++;
                $display("FAIL mov_movi: addr=%0d data=%b, required 0 111011001", wq_a[0].addr, wq_a[0].data);
            end
            total++;
            if (wq_a[1].addr !== 8'd1 || wq_a[1].data !== 9'b1_0010_0111) begin
                bad++;
                $display("FAIL mov_movr: addr=%0d data=%b, required 1 100100111", wq_a[1].addr, wq_a[1].data);
            end
            total++;
            if (wq_a[1].cyc != wq_a[0].cyc + 1) begin
                bad++;
                $display("FAIL mov_consecutive: cycles %0d,%0d, required adjacent", wq_a[0].cyc, wq_a[1].cyc);
            end
        end
    endtask

    task automatic test_illegal;
        int w;
        wq_a.delete();
        pulse_start(1'b0);
        send(5'b10011, 3'd1, 4'd1, 1'b0, 1'b0, w);
        total++;
        if (err_a !== 1'b1 || busy_a !== 1'b0 || in_ready_a !== 1'b0) begin
            bad++;
            $display("FAIL illegal_err: err=%b busy=%b rdy=%b, required 1 0 0", err_a, busy_a, in_ready_a);
        end
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (wq_a.size() != 0 || err_a !== 1'b1) begin
            bad++;
            $display("FAIL illegal_nowrite: writes=%0d err=%b, required 0 1", wq_a.size(), err_a);
        end
        pulse_start(1'b0);
        total++;
        if (err_a !== 1'b0 || busy_a !== 1'b1 || word_count_a !== 9'd0) begin
            bad++;
            $display("FAIL illegal_restart: err=%b busy=%b wc=%0d, required 0 1 0", err_a, busy_a, word_count_a);
        end
        send(5'b00101, 3'd0, 4'hA, 1'b1, 1'b0, w);
        wait_done_a("illegal");
        total++;
        if (wq_a.size() != 1 || wq_a[0].addr !== 8'd0 || wq_a[0].data !== 9'h05A) begin
            bad++;
            $display("FAIL illegal_rewrite: writes=%0d, required 1 write addr 0 data 05a", wq_a.size());
        end
    endtask

    task automatic test_back_to_back;
        int w;
        logic [8:0] exp_d [6];
        exp_d = '{9'h001, 9'h012, 9'h023, 9'h034, 9'h045, 9'h056};
        wq_a.delete();
        pulse_start(1'b0);
        for (int i = 0; i < 6; i++) begin
            send(5'(i), 3'd0, 4'(i + 1), (i == 5), 1'b0, w);
            total++;
            if (w != 0) begin
                bad++;
                $display("FAIL burst_ready_%0d: waited %0d cycles, required 0", i, w);
            end
        end
        wait_done_a("burst");
        total++;
        if (wq_a.size() != 6 || word_count_a !== 9'd6) begin
            bad++;
            $display("FAIL burst_count: writes=%0d wc=%0d, required 6 6", wq_a.size(), word_count_a);
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (wq_a[i].addr !== 8'(i) || wq_a[i].data !== exp_d[i] ||
                    (i > 0 && wq_a[i].cyc != wq_a[i-1].cyc + 1)) begin
                    bad++;
                    $display("FAIL burst_word_%0d: addr=%0d data=%h cyc=%0d, required addr %0d data %h adjacent",
                             i, wq_a[i].addr, wq_a[i].data, wq_a[i].cyc, i, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_overflow;
        int w;
        wq_b.delete();
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            send(5'b00111, 3'd0, 4'(i), 1'b0, 1'b1, w);
        end
        total++;
        if (err_b !== 1'b0) begin
            bad++;
            $display("FAIL ovf_early_err: err=%b after 4 sets, required 0", err_b);
        end
        send(5'b00111, 3'd0, 4'd4, 1'b0, 1'b1, w);
        total++;
        if (err_b !== 1'b1 || word_count_b !== 3'd4) begin
            bad++;
            $display("FAIL ovf_err: err=%b wc=%0d, required 1 4", err_b, word_count_b);
        end
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (wq_b.size() != 4 || word_count_b !== 3'd4) begin
            bad++;
            $display("FAIL ovf_writes: writes=%0d wc=%0d, required 4 4", wq_b.size(), word_count_b);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (wq_b[i].addr !== 8'(i) || wq_b[i].data !== (9'h070 + 9'(i))) begin
                    bad++;
                    $display("FAIL ovf_word_%0d: addr=%0d data=%h, required %0d %h",
                             i, wq_b[i].addr, wq_b[i].data, i, 9'h070 + 9'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid_load;
        int w;
        int snap;
        wq_a.delete();
        pulse_start(1'b0);
        send(5'b00001, 3'd0, 4'd1, 1'b0, 1'b0, w);
        send(5'b00010, 3'd0, 4'd2, 1'b0, 1'b0, w);
        in_op = 5'b00011; in_arg = 4'd3; in_last = 1'b0; in_valid = 1'b1;
        total++;
        if (mem_we_a !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_write: mem_we=%b, required 1", mem_we_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_we_a !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b0 || word_count_a !== 9'd0) begin
            bad++;
            $display("FAIL rst_async: we=%b busy=%b rdy=%b wc=%0d, required 0 0 0 0",
                     mem_we_a, busy_a, in_ready_a, word_count_a);
        end
        snap = wq_a.size();
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        total++;
        if (snap != 1 || wq_a.size() != snap || busy_a !== 1'b0 || mem_we_a !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_more_writes: before=%0d after=%0d busy=%b, required 1 1 0",
                     snap, wq_a.size(), busy_a);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_arg = '0; in_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_mov();
        test_illegal();
        test_back_to_back();
        test_overflow();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
